rns_mrc_decoder: RTL and testbench

// - Sequential RNS-to-signed-int decoder using mixed-radix conversion (MRC), driven by a valid/ready handshake.
// - Replaces the wide single-cycle CRT multiply/modulo with small 8-bit modular steps plus a Horner assembly.
// - Sits at the datapath output: RNS ALU results come in, 32-bit two's-complement ints go out.
// - Bit-exact to the CRT decode (modulus M = 3368562317) including the signed fold-back.

---
 rtl/rns_pkg.sv | 48 ++++
 rtl/common.sv | 8 +
 rtl/rns_mod_mul_lane.sv | 30 +++
 rtl/rns_mrc_decoder.sv | 160 ++++++++++++++++
 tb/tb_rns_mrc_decoder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rns_pkg.sv
// Shared RNS definitions: default moduli, range product, FSM states and
// elaboration-time helpers (modular inverse, single-step residue reduction).
// No ports; imported by the decoder and its lane sub-module.
package rns_pkg;

  localparam int unsigned RNS_M0 = 233;
  localparam int unsigned RNS_M1 = 239;
  localparam int unsigned RNS_M2 = 241;
  localparam int unsigned RNS_M3 = 251;
  localparam longint unsigned RNS_M =
      64'(RNS_M0) * 64'(RNS_M1) * 64'(RNS_M2) * 64'(RNS_M3);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MRC    = 3'd1,
    HORNER = 3'd2,
    FIX    = 3'd3,
    OUT    = 3'd4
  } state_t;

  // a^-1 mod m by extended Euclid; returns 0 when no inverse exists
  // (used only on constants, so it folds away at elaboration).
  function automatic int unsigned mod_inv(input int unsigned a, input int unsigned m);
    int old_r, r, old_s, s, q, t;
    old_r = int'(a % m);
    r     = int'(m);
    old_s = 1;
    s     = 0;
    while (r != 0) begin
      q     = old_r / r;
      t     = old_r - q * r;
      old_r = r;
      r     = t;
      t     = old_s - q * s;
      old_s = s;
      s     = t;
    end
    if (old_r != 1) return 0;
    return unsigned'(((old_s % int'(m)) + int'(m)) % int'(m));
  endfunction

  // An 8-bit value is below 2*m for every modulus >= 128, so one
  // conditional subtract is a full reduction.
  function automatic logic [7:0] reduce_once(input logic [7:0] x, input int unsigned m);
    return (32'(x) >= m) ? 8'(32'(x) - m) : x;
  endfunction

endpackage

// File: rtl/common.sv
`ifndef RNS_COMMON_SV
`define RNS_COMMON_SV
// Signed fold-back constants for the default RNS range M = 3368562317.
// Decoded values at or above the middle point represent negatives; adding
// the delta (2^32 - M) maps them onto their 32-bit two's-complement form.
`define RNS_MIDDLE_POINT 32'd1684281159
`define INT_RNS_DELTA    32'd926404979
`endif

// File: rtl/rns_mod_mul_lane.sv
// One MRC lane step: res = ((r + M - (v mod M)) * inv) mod M for a constant M.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Ports: r = lane residue (< M), v = current mixed-radix digit, inv = M_k^-1 mod M.
module rns_mod_mul_lane #(
  parameter int unsigned M = 239
) (
  input  logic [7:0] r,
  input  logic [7:0] v,
  input  logic [7:0] inv,
  output logic [7:0] res
);
  localparam logic [8:0]  M9  = 9'(M);
  localparam logic [15:0] M16 = 16'(M);

  logic [8:0]  v_red;
  logic [8:0]  sum;
  logic [7:0]  diff;
  logic [15:0] prod;

  always_comb begin
    v_red = ({1'b0, v} >= M9) ? ({1'b0, v} - M9) : {1'b0, v};
    // r + M - v lies in (0, 2M); fold it below M before the multiply so the
    // product stays within 16 bits and the final modulo is by a constant.
    sum   = {1'b0, r} + M9 - v_red;
    diff  = 8'((sum >= M9) ? (sum - M9) : sum);
    prod  = 16'(diff) * 16'(inv);
    res   = 8'(prod % M16);
  end

endmodule

// File: rtl/rns_mrc_decoder.sv
// RNS {r3,r2,r1,r0} to signed 32-bit int via mixed-radix conversion + Horner.
// Latency: 7 edges from accept to out_valid (3 MRC, 3 HORNER, 1 FIX).
// Backpressure: single conversion in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk/rst_n; in_valid/in_ready/rns_in (input handshake);
//        out_valid/out_ready/int_out/out_err (output handshake, err = out-of-range residue).
`ifndef RNS_MIDDLE_POINT
`include "common.sv"
`endif

module rns_mrc_decoder
  import rns_pkg::*;
#(
  parameter int unsigned M0 = RNS_M0,
  parameter int unsigned M1 = RNS_M1,
  parameter int unsigned M2 = RNS_M2,
  parameter int unsigned M3 = RNS_M3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rns_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        out_err
);

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  // Residue registers; lane k freezes after MRC step k and then holds digit v_k.
  logic [7:0]  r_q [4];
  logic [7:0]  r_d [4];
  logic [31:0] acc_q, acc_d;
  logic [31:0] int_out_q, int_out_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [7:0]  v_cur;
  logic [7:0]  lane_res [1:3];
  logic [7:0]  h_mul;
  logic [7:0]  h_dig;

  assign v_cur = r_q[step_q];

  for (genvar j = 1; j < 4; j++) begin : g_lane
    localparam int unsigned MJ = (j == 1) ? M1 : (j == 2) ? M2 : M3;
    // Inverses of the digit moduli; entries with k >= j come out 0 and are
    // never used because those lanes are frozen by then.
    localparam logic [7:0] INV_K0 = 8'(mod_inv(M0, MJ));
    localparam logic [7:0] INV_K1 = 8'(mod_inv(M1, MJ));
    localparam logic [7:0] INV_K2 = 8'(mod_inv(M2, MJ));

    logic [7:0] inv_sel;
    assign inv_sel = (step_q == 2'd0) ? INV_K0 :
                     (step_q == 2'd1) ? INV_K1 : INV_K2;

    rns_mod_mul_lane #(.M(MJ)) u_lane (
      .r   (r_q[j]),
      .v   (v_cur),
      .inv (inv_sel),
      .res (lane_res[j])
    );
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    r_d         = r_q;
    acc_d       = acc_q;
    int_out_d   = int_out_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    h_mul       = 8'(M0);
    h_dig       = r_q[0];

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          r_d[0]  = reduce_once(rns_in[7:0],   M0);
          r_d[1]  = reduce_once(rns_in[15:8],  M1);
          r_d[2]  = reduce_once(rns_in[23:16], M2);
          r_d[3]  = reduce_once(rns_in[31:24], M3);
          err_d   = (32'(rns_in[7:0])   >= M0) || (32'(rns_in[15:8])  >= M1) ||
                    (32'(rns_in[23:16]) >= M2) || (32'(rns_in[31:24]) >= M3);
          step_d  = 2'd0;
          state_d = MRC;
        end
      end
      MRC: begin
        for (int j = 1; j < 4; j++) begin
          if (j > int'(step_q)) r_d[j] = lane_res[j];
        end
        if (step_q == 2'd2) begin
          // First Horner step folded in: acc starts at the final digit v3.
          acc_d   = {24'd0, lane_res[3]};
          step_d  = 2'd0;
          state_d = HORNER;
        end else begin
          step_d  = step_q + 2'd1;
        end
      end
      HORNER: begin
        h_mul = (step_q == 2'd0) ? 8'(M2) : (step_q == 2'd1) ? 8'(M1) : 8'(M0);
        h_dig = r_q[2'(2'd2 - step_q)];
        // acc < M keeps the 40-bit product's low 32 bits exact.
        acc_d = 32'(40'(acc_q) * 40'(h_mul) + 40'(h_dig));
        if (step_q == 2'd2) begin
          step_d  = 2'd0;
          state_d = FIX;
        end else begin
          step_d  = step_q + 2'd1;
        end
      end
      FIX: begin
        int_out_d   = (acc_q >= `RNS_MIDDLE_POINT) ? (acc_q + `INT_RNS_DELTA) : acc_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      for (int i = 0; i < 4; i++) r_q[i] <= 8'd0;
      acc_q       <= 32'd0;
      int_out_q   <= 32'd0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      int_out_q   <= int_out_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign int_out   = int_out_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_rns_mrc_decoder.sv
// Bench for rns_mrc_decoder: directed scenarios plus random round-trips
// against an arithmetic encode / CRT-decode reference model.
// Ports: drives every DUT port; clock is a free-running 10 ns period.
module tb_rns_mrc_decoder;

  localparam longint MM   = 64'sd3368562317;
  localparam longint HALF = (MM - 1) / 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rns_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        out_err;

  int checks   = 0;
  int failures = 0;
  longint mods [4] = '{233, 239, 241, 251};

  always #5 clk = ~clk;

  rns_mrc_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rns_in    (rns_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .out_err   (out_err)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] encode(input longint x);
    longint n;
    logic [31:0] w;
    w = '0;
    n = (x < 0) ? x + MM : x;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(n % mods[i]);
    return w;
  endfunction

  function automatic logic [31:0] crt_decode(input logic [31:0] w);
    longint acc, mi, r, inv, n;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      r   = longint'(w[8*i +: 8]) % mods[i];
      mi  = MM / mods[i];
      inv = 0;
      for (longint x = 1; x < mods[i]; x++)
        if (((mi % mods[i]) * x) % mods[i] == 1) inv = x;
      acc = (acc + r * mi * inv) % MM;
    end
    n = (acc > HALF) ? acc - MM : acc;
    return 32'(n);
  endfunction

  function automatic logic raw_err(input logic [31:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 4; i++) if (longint'(w[8*i +: 8]) >= mods[i]) e = 1'b1;
    return e;
  endfunction

  // ---------------- driver ----------------
  // Precondition: called at posedge+1. Returns at posedge+1 after the handshake edge.
  task automatic decode(input logic [31:0] w, output logic [31:0] res,
                        output logic err, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      failures++;
      $display("FAIL decode_wait_in_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1;
    rns_in   = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (lat >= 20) begin
      failures++;
      $display("FAIL decode_wait_out_valid: no out_valid within %0d cycles, required 7", lat);
    end
    res = int_out;
    err = out_err;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; rns_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (int_out !== 32'd0) begin failures++; $display("FAIL reset_int_out: got %h, required 0", int_out); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err: got %b, required 0", out_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_release_out_valid: got %b, required 0", out_valid); end
  endtask

  task automatic test_zero_one();
    logic [31:0] res; logic err; int lat;
    decode(32'h00000000, res, err, lat);
    checks++; if (res !== 32'd0) begin failures++; $display("FAIL zero_value: got %h, required 0", res); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL zero_err: got %b, required 0", err); end
    checks++; if (lat != 7) begin failures++; $display("FAIL zero_latency: got %0d, required 7", lat); end
    decode(32'h01010101, res, err, lat);
    checks++; if (res !== 32'd1) begin failures++; $display("FAIL one_value: got %h, required 1", res); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL one_err: got %b, required 0", err); end
    checks++; if (lat != 7) begin failures++; $display("FAIL one_latency: got %0d, required 7", lat); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL one_in_ready_after: got %b, required 1", in_ready); end
  endtask

  task automatic test_positive();
    logic [31:0] res; logic err; int lat;
    decode(32'h2E369CE5, res, err, lat);
    checks++; if (res !== 32'd12345) begin failures++; $display("FAIL positive_12345: got %0d, required 12345", res); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL positive_err: got %b, required 0", err); end
  endtask

  task automatic test_negative();
    logic [31:0] res; logic err; int lat;
    decode({8'd250, 8'd240, 8'd238, 8'd232}, res, err, lat);
    checks++; if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL negative_minus1: got %h, required ffffffff", res); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL negative_err: got %b, required 0", err); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp;
    int n;
    exp = 32'(-64'sd777);
    out_ready = 1'b0;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    in_valid = 1'b1;
    rns_in   = encode(-777);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (int_out !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: int_out=%h out_valid=%b in_ready=%b, required %h 1 0",
                 i, int_out, out_valid, in_ready, exp);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res; logic err; int lat;
    int seen;
    in_valid = 1'b1;
    rns_in   = encode(4242);
    @(posedge clk); #1;            // accept edge; first MRC cycle
    in_valid = 1'b0;
    @(posedge clk); #1;            // second MRC cycle
    @(posedge clk); #1;            // third MRC cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_asserted: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_output: out_valid seen %0d cycles, required 0", seen); end
    decode(encode(-31337), res, err, lat);
    checks++; if (res !== 32'(-64'sd31337)) begin failures++; $display("FAIL midrst_next: got %h, required %h", res, 32'(-64'sd31337)); end
  endtask

  task automatic test_invalid_residue();
    logic [31:0] res, w, exp; logic err; int lat;
    w   = {8'd46, 8'd54, 8'd156, 8'd240};
    exp = crt_decode(w);
    decode(w, res, err, lat);
    checks++; if (res !== exp) begin failures++; $display("FAIL invalid_value: got %h, required %h", res, exp); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL invalid_err: got %b, required 1", err); end
    decode(32'h2E369CE5, res, err, lat);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL invalid_err_clears: got %b, required 0", err); end
  endtask

  task automatic test_random_roundtrip();
    logic [31:0] res, exp; logic err; int lat;
    longint n, x;
    for (int i = 0; i < 3000; i++) begin
      n = longint'($urandom_range(32'd3368562316, 32'd0));
      x = (n > HALF) ? n - MM : n;
      if (i < 4) x = (i == 0) ? HALF : (i == 1) ? -HALF : (i == 2) ? HALF - 1 : -HALF + 1;
      exp = 32'(x);
      decode(encode(x), res, err, lat);
      checks++;
      if (res !== exp || err !== 1'b0 || lat != 7) begin
        failures++;
        $display("FAIL roundtrip_%0d: x=%0d got %h err=%b lat=%0d, required %h err=0 lat=7",
                 i, x, res, err, lat, exp);
      end
    end
  endtask

  task automatic test_random_raw();
    logic [31:0] res, exp, w; logic err, exp_err; int lat;
    for (int i = 0; i < 800; i++) begin
      w       = $urandom;
      exp     = crt_decode(w);
      exp_err = raw_err(w);
      decode(w, res, err, lat);
      checks++;
      if (res !== exp || err !== exp_err) begin
        failures++;
        $display("FAIL raw_%0d: rns=%h got %h err=%b, required %h err=%b",
                 i, w, res, err, exp, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_one();
    test_positive();
    test_negative();
    test_back_pressure();
    test_reset_mid_op();
    test_invalid_residue();
    test_random_roundtrip();
    test_random_raw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
